sys_bridge: RTL and testbench

SYS_BRIDGE -- requirements
Module: sys_bridge

---
 rtl/sys_bus_pkg.sv | 24 ++
 rtl/sys_bridge_decode.sv | 26 ++
 rtl/sys_bridge.sv | 100 ++++++++++
 tb/tb_sys_bridge.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared definitions for the CPU-to-timer bridge: window bases, register
// offsets, FSM encoding and the latched request record.
package sys_bus_pkg;

  localparam logic [31:0] T0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] T1_BASE_DEF = 32'h0000_7F10;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PRESET = 4'h4;
  localparam logic [3:0] REG_COUNT  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sys_bridge_decode.sv
// Combinational address decode: which timer window is hit and whether the
// access must be rejected with a bus error.
module sys_bridge_decode
  import sys_bus_pkg::*;
#(
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF
) (
  input  logic [31:0] addr,
  input  logic        we,
  output logic [1:0]  hit,
  output logic        err
);

  logic in_win;

  always_comb begin
    // Each window holds three word registers; the fourth slot is a hole.
    in_win = (addr[3:2] != 2'd3);
    hit[0] = (addr[31:4] == T0_BASE[31:4]) && in_win;
    hit[1] = (addr[31:4] == T1_BASE[31:4]) && in_win;
    err    = ~(|hit) || (|addr[1:0]) ||
             (we && (addr[3:2] == REG_COUNT[3:2]));
  end

endmodule

// File: rtl/sys_bridge.sv
// Bridge from a single-outstanding CPU request bus to two timer register
// windows; three-state IDLE/ACCESS/RESP handshake plus interrupt forwarding.
module sys_bridge
  import sys_bus_pkg::*;
#(
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [7:0]  dev_addr,
  output logic [31:0] dev_din,
  output logic [1:0]  dev_we,
  input  logic [31:0] dev0_dout,
  input  logic [31:0] dev1_dout,
  input  logic [1:0]  dev_irq,
  output logic [5:0]  hwint
);

  bridge_state_e state_q, state_d;
  bus_req_t      req_q, req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [1:0]    hwint_q, hwint_d;

  logic [1:0]    dec_hit;
  logic          dec_err;

  sys_bridge_decode #(
    .T0_BASE(T0_BASE),
    .T1_BASE(T1_BASE)
  ) u_decode (
    .addr(req_q.addr),
    .we  (req_q.we),
    .hit (dec_hit),
    .err (dec_err)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    hwint_d  = dev_irq;
    dev_we   = 2'b00;
    dev_addr = 8'h00;
    dev_din  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          req_d   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        dev_addr = {4'h0, req_q.addr[3:0]};
        dev_din  = req_q.wdata;
        err_d    = dec_err;
        rdata_d  = 32'h0;
        // Strobe is masked by reset so an aborted write never lands.
        if (!dec_err && req_q.we && !reset)
          dev_we = dec_hit;
        if (!dec_err && !req_q.we)
          rdata_d = dec_hit[1] ? dev1_dout : dev0_dout;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      hwint_q <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hwint_q <= hwint_d;
    end
  end

  assign cpu_ready = (state_q == ST_RESP);
  assign cpu_rdata = cpu_ready ? rdata_q : 32'h0;
  assign cpu_err   = cpu_ready & err_q;
  assign hwint     = {4'b0000, hwint_q};

endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: expected responses are queued at issue
// and retired by a monitor whenever cpu_ready pulses.
module tb_sys_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [7:0]  dev_addr;
  logic [31:0] dev_din;
  logic [1:0]  dev_we;
  logic [31:0] dev0_dout, dev1_dout;
  logic [1:0]  dev_irq;
  logic [5:0]  hwint;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sys_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_addr(dev_addr), .dev_din(dev_din), .dev_we(dev_we),
    .dev0_dout(dev0_dout), .dev1_dout(dev1_dout),
    .dev_irq(dev_irq), .hwint(hwint)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ready pulse must retire one queued expectation.
  always @(negedge clk) begin
    if (cpu_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", cpu_rdata, e.rdata);
        chk("sb_err", {31'b0, cpu_err}, {31'b0, e.err});
      end
    end
  end

  // One full transaction: accept (c0), ACCESS (c1), RESP (c2), idle (c3).
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] exp_we, input logic [31:0] exp_rdata,
                      input logic exp_err);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    chk("c0_dev_we", {30'b0, dev_we}, 32'd0);
    chk("c0_dev_addr", {24'b0, dev_addr}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("acc_dev_we", {30'b0, dev_we}, {30'b0, exp_we});
    chk("acc_ready", {31'b0, cpu_ready}, 32'd0);
    if (!exp_err) chk("acc_dev_addr", {24'b0, dev_addr}, {28'b0, addr[3:0]});
    if (!exp_err && we) chk("acc_dev_din", dev_din, wdata);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_ready", {31'b0, cpu_ready}, 32'd1);
    chk("resp_dev_we", {30'b0, dev_we}, 32'd0);
    chk("resp_dev_din", dev_din, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("post_ready", {31'b0, cpu_ready}, 32'd0);
    chk("post_dev_we", {30'b0, dev_we}, 32'd0);
    chk("post_rdata", cpu_rdata, 32'd0);
    chk("post_err", {31'b0, cpu_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev0_dout = 32'hCAFE_0008; dev1_dout = 32'h0000_1234; dev_irq = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_hwint", {26'b0, hwint}, 32'd0);
    chk("rst_dev_we", {30'b0, dev_we}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dev_irq = 2'b00;
    @(posedge clk); #1;

    xfer(1'b1, 32'h0000_7F00, 32'h0000_000B, 2'b01, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_7F14, 32'h0,         2'b00, 32'h0000_1234, 1'b0);
    xfer(1'b0, 32'h0000_7F20, 32'h0,         2'b00, 32'h0, 1'b1);
    xfer(1'b1, 32'h0000_7F02, 32'h1111_2222, 2'b00, 32'h0, 1'b1);
    xfer(1'b1, 32'h0000_7F18, 32'h3333_4444, 2'b00, 32'h0, 1'b1);
    xfer(1'b0, 32'h0000_7F08, 32'h0,         2'b00, 32'hCAFE_0008, 1'b0);
    xfer(1'b1, 32'h0000_7F14, 32'h0000_0055, 2'b10, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_7F0C, 32'h0,         2'b00, 32'h0, 1'b1);
    xfer(1'b1, 32'h0000_7F08, 32'h0000_0001, 2'b00, 32'h0, 1'b1);

    // Interrupt forwarding: one cycle of latency, upper bits stay zero.
    @(posedge clk); #1;
    dev_irq = 2'b01;
    @(negedge clk);
    chk("irq_k", {26'b0, hwint}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_k1", {26'b0, hwint}, 32'h01);
    @(posedge clk); #1;
    dev_irq = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_t1", {26'b0, hwint}, 32'h02);
    dev_irq = 2'b00;

    // Reset in the ACCESS cycle of a write aborts it.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F04; cpu_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_dev_we", {30'b0, dev_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, cpu_ready}, 32'd0);
    chk("abort_dev_addr", {24'b0, dev_addr}, 32'd0);
    chk("abort_hwint", {26'b0, hwint}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready2", {31'b0, cpu_ready}, 32'd0);
    chk("abort_dev_we2", {30'b0, dev_we}, 32'd0);

    xfer(1'b1, 32'h0000_7F04, 32'h0000_00AA, 2'b01, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
